uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 100_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9_600, meaning the serial bit rate; DIV = CLOCK_HZ/BAUD (integer), DIV >= 4.
REQ-003 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  system clock; all state rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port addr  input  `ADDR_WIDTH  CPU byte address (same bus as memory).
REQ-007 SHALL have port wr  input  1  write strobe, one cycle per access.
REQ-008 SHALL have port rd  input  1  read strobe, one cycle per access.
REQ-009 SHALL have port wr_data  input  16  write data; only [7:0] used.
REQ-010 SHALL have port rd_data  output  16  read data, valid the cycle after the rd cycle.
REQ-011 SHALL have port sel_d  output  1  high the cycle after any access hitting 0x082 or 0x084, for the top-level rd_data mux.
REQ-012 SHALL have port txd  output  1  serial out, idle high.
REQ-013 SHALL have port rxd  input  1  serial in, asynchronous to clk.

Function
REQ-014 SHALL decode DATA at addr 0x082 and STAT at 0x084; other addresses are ignored, with rd_data = 0 and sel_d = 0 next cycle.
REQ-015 SHALL push wr_data[7:0] into the TX FIFO on wr to DATA when not full; write when full is dropped and sets tx_ovf.
REQ-016 SHALL return {8'h00, rx_byte} on rd to DATA (registered, 1-cycle latency), clear rx_valid and rx_ovr, and return 0 in [7:0] if rx_valid was 0.
REQ-017 SHALL return STAT = {11'b0, ferr, tx_ovf, rx_ovr, rx_valid, tx_full, tx_empty}[15:0] on STAT read; bit0 tx_empty = FIFO empty AND TX FSM IDLE; bit1 tx_full; bit2 rx_valid; bit3 rx_ovr; bit4 tx_ovf; bit5 ferr.
REQ-018 SHALL clear tx_ovf and ferr on any STAT read (value returned is pre-clear).
REQ-019 SHALL implement TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, each state/bit held exactly DIV clocks; 8N1 frame = 10*DIV clocks.
REQ-020 SHALL leave IDLE the cycle after FIFO non-empty, popping the head; back-to-back bytes SHALL have no idle gap (STOP -> START directly if FIFO non-empty).
REQ-021 SHALL allow simultaneous push and pop on a full FIFO: pop frees the slot, push accepted, no tx_ovf.
REQ-022 SHALL synchronise rxd through 2 flops before use; sync flops reset to 1.
REQ-023 SHALL implement RX FSM IDLE -> START -> DATA -> STOP -> IDLE; IDLE detects synced rxd = 0; START re-samples at DIV/2 clocks and returns to IDLE if 1 (glitch reject).
REQ-024 SHALL sample each data bit DIV clocks after the previous sample point (mid-bit), LSB first, then sample stop bit.
REQ-025 SHALL, stop bit = 1: load rx_byte, set rx_valid; if rx_valid was already 1, overwrite and set rx_ovr.
REQ-026 SHALL, stop bit = 0: discard byte, set ferr, leave rx_valid unchanged, wait for synced rxd = 1 before IDLE.
REQ-027 SHALL, rd of DATA in the same cycle as a new byte completes: new byte wins (rx_valid = 1 after), returned value is the old byte, rx_ovr not set.
REQ-028 SHALL wrap FIFO pointers modulo TX_DEPTH using an extra pointer bit for full/empty distinction.

Reset
REQ-029 SHALL on rst: txd = 1, rd_data = 0, sel_d = 0, both FSMs IDLE, FIFO empty, rx_byte = 0, all flags 0, baud counters 0.
REQ-030 SHALL, rst asserted mid-frame, force txd = 1 immediately (async) and discard the partial frame and FIFO contents.

Verification (bench: CLOCK_HZ=16, BAUD=1, DIV=16, TX_DEPTH=4)
REQ-031 SHALL cover: wr DATA 0x0055 -> txd low for 16 clks from cycle after wr, then bits 1,0,1,0,1,0,1,0 each 16 clks, stop high 16 clks; STAT bit0 = 1 after 160 clks.
REQ-032 SHALL cover: 6 writes 0x41..0x46 back-to-back -> first popped to FSM, 0x42..0x45 fill FIFO, 0x46 dropped; STAT reads 0x0012; txd shows 0x41..0x45 with no gaps.
REQ-033 SHALL cover: drive rxd frame 0xA3 at 16 clks/bit -> rx_valid = 1 within 3 clks of stop mid-sample; rd DATA -> rd_data = 0x00A3 next cycle, STAT then 0x0001.
REQ-034 SHALL cover: two frames 0x11, 0x22 without read -> rd DATA returns 0x0022, STAT before it shows bits2,3 set (0x000D).
REQ-035 SHALL cover: rxd low pulse of 5 clks -> no byte, no ferr; frame 0x7F with stop bit 0 -> STAT = 0x0021, second STAT read = 0x0001.
REQ-036 SHALL cover: rst pulse during TX bit 3 of 0x0F -> txd = 1 same cycle as rst, STAT = 0x0001 after release, no further transmission.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with a transmit FIFO and a single-byte
// receive holding register.
//
// Register map (byte addresses on the CPU bus):
//   0x082 DATA  write: push wr_data[7:0] into the TX FIFO
//               read : {8'h00, rx_byte}, or 0 when no byte is held; clears
//                      rx_valid and rx_ovr
//   0x084 STAT  read : {10'b0, ferr, tx_ovf, rx_ovr, rx_valid, tx_full, tx_empty}
//                      tx_ovf and ferr clear on read (the pre-clear value is
//                      returned)
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      asynchronous, active-high reset
//   addr     CPU byte address
//   wr, rd   one-cycle write / read strobes
//   wr_data  write data, only [7:0] used
//   rd_data  read data, registered, valid the cycle after rd
//   sel_d    high the cycle after any access to DATA or STAT
//   txd      serial out, idles high
//   rxd      serial in, asynchronous to clk

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module uart_mmio #(
  parameter int unsigned CLOCK_HZ = 100_000,
  parameter int unsigned BAUD     = 9_600,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`ADDR_WIDTH-1:0] addr,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [15:0]            wr_data,
  output logic [15:0]            rd_data,
  output logic                   sel_d,
  output logic                   txd,
  input  logic                   rxd
);

  localparam int unsigned DIV  = CLOCK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam int unsigned AW   = $clog2(TX_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  localparam logic [`ADDR_WIDTH-1:0] ADDR_DATA = `ADDR_WIDTH'('h082);
  localparam logic [`ADDR_WIDTH-1:0] ADDR_STAT = `ADDR_WIDTH'('h084);

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic w_hit_data;
  logic w_hit_stat;
  logic w_rd_data;
  logic w_rd_stat;
  logic w_wr_data;

  assign w_hit_data = (addr == ADDR_DATA);
  assign w_hit_stat = (addr == ADDR_STAT);
  assign w_rd_data  = rd & w_hit_data;
  assign w_rd_stat  = rd & w_hit_stat;
  assign w_wr_data  = wr & w_hit_data;

  logic w_unused;
  assign w_unused = ^wr_data[15:8];

  // --------------------------------------------------------------------------
  // TX FIFO: pointers carry one extra bit so full and empty are distinguishable
  // --------------------------------------------------------------------------
  logic [7:0]  r_fifo [TX_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic [7:0]  w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_fifo[r_rptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a write to a full FIFO is
  // still accepted then.
  assign w_tx_push = w_wr_data && (!w_full || w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_fifo[r_wptr[AW-1:0]] <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_tx_push) r_wptr <= r_wptr + 1'b1;
      if (w_tx_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  tx_state_e     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_txd;
  logic          w_tx_empty;
  logic          r_tx_ovf;

  // Pop when idle, or at the end of a stop bit so frames run back to back.
  assign w_tx_pop = !w_empty &&
                    ((r_tx_state == TxIdle) ||
                     ((r_tx_state == TxStop) && (r_tx_cnt == CNT_LAST)));

  assign w_tx_empty = w_empty && (r_tx_state == TxIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      unique case (r_tx_state)
        TxIdle: begin
          if (w_tx_pop) begin
            r_tx_shift <= w_head;
            r_tx_cnt   <= '0;
            r_txd      <= 1'b0;
            r_tx_state <= TxStart;
          end
        end
        TxStart: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_state <= TxData;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TxData: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TxStop;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TxStop: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shift <= w_head;
              r_txd      <= 1'b0;
              r_tx_state <= TxStart;
            end else begin
              r_tx_state <= TxIdle;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          r_tx_state <= TxIdle;
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

  assign txd = r_txd;

  // A dropped write in the same cycle as a STAT read keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
    end else if (w_wr_data && w_full && !w_tx_pop) begin
      r_tx_ovf <= 1'b1;
    end else if (w_rd_stat) begin
      r_tx_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // RX synchroniser
  // --------------------------------------------------------------------------
  logic r_rx_sync1;
  logic r_rx_sync2;
  logic w_rxd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= rxd;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  assign w_rxd = r_rx_sync2;

  // --------------------------------------------------------------------------
  // RX FSM and receive flags
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

  rx_state_e     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid;
  logic          r_rx_ovr;
  logic          r_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      // Bus-side clears first; frame completion below overrides them.
      if (w_rd_data) begin
        r_rx_valid <= 1'b0;
        r_rx_ovr   <= 1'b0;
      end
      if (w_rd_stat) begin
        r_ferr <= 1'b0;
      end

      unique case (r_rx_state)
        RxIdle: begin
          if (!w_rxd) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RxStart;
          end
        end
        RxStart: begin
          if (r_rx_cnt == CNT_HALF) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            r_rx_state <= w_rxd ? RxIdle : RxData;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RxData: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RxStop;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RxStop: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt <= '0;
            if (w_rxd) begin
              r_rx_byte  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              // A DATA read this cycle consumes the old byte: no overrun.
              if (r_rx_valid && !w_rd_data) begin
                r_rx_ovr <= 1'b1;
              end
              r_rx_state <= RxIdle;
            end else begin
              r_ferr     <= 1'b1;
              r_rx_state <= RxBreak;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RxBreak: begin
          // Hold off until the line returns high so a break is not re-read.
          if (w_rxd) begin
            r_rx_state <= RxIdle;
          end
        end
        default: begin
          r_rx_state <= RxIdle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read data and select registers
  // --------------------------------------------------------------------------
  logic [15:0] w_stat;
  logic [15:0] r_rd_data;
  logic        r_sel_d;

  assign w_stat = {10'b0, r_ferr, r_tx_ovf, r_rx_ovr, r_rx_valid, w_full, w_tx_empty};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
      r_sel_d   <= 1'b0;
    end else begin
      if (w_rd_data) begin
        r_rd_data <= {8'h00, (r_rx_valid ? r_rx_byte : 8'h00)};
      end else if (w_rd_stat) begin
        r_rd_data <= w_stat;
      end else begin
        r_rd_data <= '0;
      end
      r_sel_d <= (rd | wr) & (w_hit_data | w_hit_stat);
    end
  end

  assign rd_data = r_rd_data;
  assign sel_d   = r_sel_d;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed bench for uart_mmio at CLOCK_HZ=16, BAUD=1 (16 clocks
// per bit) with a 4-entry TX FIFO. Register-decode vectors are table driven;
// serial transmit/receive and reset cases are hand-written sequences.

module tb_uart_mmio;

  localparam int unsigned CLOCK_HZ = 16;
  localparam int unsigned BAUD     = 1;
  localparam int unsigned TX_DEPTH = 4;

  localparam logic [15:0] A_DATA = 16'h0082;
  localparam logic [15:0] A_STAT = 16'h0084;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] addr    = 16'h0000;
  logic        wr      = 1'b0;
  logic        rd      = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] rd_data;
  logic        sel_d;
  logic        txd;
  logic        rxd     = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  uart_mmio #(
    .CLOCK_HZ(CLOCK_HZ),
    .BAUD    (BAUD),
    .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wr     (wr),
    .rd     (rd),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .sel_d  (sel_d),
    .txd    (txd),
    .rxd    (rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic        r;
    logic        w;
    logic [15:0] exp_rd;
    logic        exp_sel;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, required 0x%04h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr    = a;
    wr_data = d;
    wr      = 1'b1;
    tick();
    wr   = 1'b0;
    addr = 16'h0000;
  endtask

  task automatic read_check(input logic [15:0] a, input logic [15:0] exp, input string name);
    addr = a;
    rd   = 1'b1;
    tick();
    rd   = 1'b0;
    addr = 16'h0000;
    check(name, rd_data, exp);
  endtask

  // Called with sample index start_i of the frame already current (index 0 is
  // the first clock after the start bit began). Optionally writes push_val to
  // DATA on the final clock edge of the frame, i.e. the edge that pops the next byte.
  task automatic check_frame(input logic [7:0] b, input int start_i, input logic push,
                             input logic [15:0] push_val, input string tag);
    logic [9:0] bits;
    int         bad;
    bits = {1'b1, b, 1'b0};
    bad  = 0;
    for (int k = start_i; k < 160; k++) begin
      if (txd !== bits[k/16]) bad++;
      if ((k % 16) == 15) begin
        n_checks++;
        if (bad != 0) begin
          n_errors++;
          $display("FAIL %s frame bit %0d: txd wrong on %0d clocks, required %b", tag, k / 16,
                   bad, bits[k/16]);
        end
        bad = 0;
      end
      if (k == 159 && push) begin
        addr    = A_DATA;
        wr_data = push_val;
        wr      = 1'b1;
      end
      tick();
      if (k == 159 && push) begin
        wr   = 1'b0;
        addr = 16'h0000;
      end
    end
  endtask

  // Drives one 16-clock-per-bit frame on rxd. If probe_a is nonzero, a read of
  // probe_a is issued on clock probe_j of the stop bit and its data returned.
  task automatic send_rx(input logic [7:0] b, input logic stop, input logic [15:0] probe_a,
                         input int probe_j, output logic [15:0] probe_got);
    probe_got = 16'h0000;
    rxd = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) tick();
    end
    rxd = stop;
    for (int j = 0; j < 16; j++) begin
      if (probe_a != 16'h0000 && j == probe_j) begin
        addr = probe_a;
        rd   = 1'b1;
      end
      tick();
      if (probe_a != 16'h0000 && j == probe_j) begin
        rd        = 1'b0;
        addr      = 16'h0000;
        probe_got = rd_data;
      end
    end
    rxd = 1'b1;
  endtask

  initial begin
    logic [15:0] got;
    int          bad;

    vecs[0] = '{16'h0084, 1'b1, 1'b0, 16'h0001, 1'b1, "rd STAT after reset"};
    vecs[1] = '{16'h0082, 1'b1, 1'b0, 16'h0000, 1'b1, "rd DATA empty"};
    vecs[2] = '{16'h0084, 1'b1, 1'b0, 16'h0001, 1'b1, "rd STAT again"};
    vecs[3] = '{16'h0084, 1'b0, 1'b0, 16'h0000, 1'b0, "idle cycle"};
    vecs[4] = '{16'h0080, 1'b1, 1'b0, 16'h0000, 1'b0, "rd 0x080"};
    vecs[5] = '{16'h0083, 1'b1, 1'b0, 16'h0000, 1'b0, "rd 0x083"};
    vecs[6] = '{16'h0085, 1'b1, 1'b0, 16'h0000, 1'b0, "rd 0x085"};
    vecs[7] = '{16'h0084, 1'b0, 1'b1, 16'h0000, 1'b1, "wr STAT"};
    vecs[8] = '{16'h0086, 1'b0, 1'b1, 16'h0000, 1'b0, "wr 0x086"};
    vecs[9] = '{16'h0184, 1'b1, 1'b0, 16'h0000, 1'b0, "rd 0x184"};

    // Reset state
    tick();
    tick();
    check("reset txd", {15'b0, txd}, 16'h0001);
    check("reset rd_data", rd_data, 16'h0000);
    check("reset sel_d", {15'b0, sel_d}, 16'h0000);
    rst = 1'b0;
    tick();

    // Register decode table
    for (int i = 0; i < 10; i++) begin
      addr    = vecs[i].a;
      rd      = vecs[i].r;
      wr      = vecs[i].w;
      wr_data = 16'h00AA;
      tick();
      rd   = 1'b0;
      wr   = 1'b0;
      addr = 16'h0000;
      check({vecs[i].name, " rd_data"}, rd_data, vecs[i].exp_rd);
      check({vecs[i].name, " sel_d"}, {15'b0, sel_d}, {15'b0, vecs[i].exp_sel});
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) bad++;
      tick();
    end
    check("txd idle after non-DATA writes (bad clocks)", 16'(bad), 16'h0000);
    read_check(A_STAT, 16'h0001, "stat after decode table");

    // Single byte 0x55
    bus_write(A_DATA, 16'h0055);
    tick();
    check_frame(8'h55, 0, 1'b0, 16'h0000, "tx 0x55");
    read_check(A_STAT, 16'h0001, "stat after tx 0x55");

    // Burst into a full FIFO, then a write on the pop edge of a full FIFO
    bus_write(A_DATA, 16'h0041);
    for (int i = 0; i < 5; i++) begin
      bus_write(A_DATA, 16'h0042 + 16'(i));
    end
    read_check(A_STAT, 16'h0012, "stat full+ovf");
    check_frame(8'h41, 5, 1'b1, 16'h0047, "tx 0x41");
    check_frame(8'h42, 0, 1'b0, 16'h0000, "tx 0x42");
    check_frame(8'h43, 0, 1'b0, 16'h0000, "tx 0x43");
    check_frame(8'h44, 0, 1'b0, 16'h0000, "tx 0x44");
    check_frame(8'h45, 0, 1'b0, 16'h0000, "tx 0x45");
    check_frame(8'h47, 0, 1'b0, 16'h0000, "tx 0x47");
    read_check(A_STAT, 16'h0001, "stat after burst");

    // Receive 0xA3, STAT probed 4 clocks after the stop-bit midpoint
    send_rx(8'hA3, 1'b1, A_STAT, 11, got);
    check("stat just after rx 0xA3", got, 16'h0005);
    read_check(A_DATA, 16'h00A3, "rd DATA 0xA3");
    read_check(A_STAT, 16'h0001, "stat after DATA read");

    // Overrun
    send_rx(8'h11, 1'b1, 16'h0000, 0, got);
    send_rx(8'h22, 1'b1, 16'h0000, 0, got);
    read_check(A_STAT, 16'h000D, "stat overrun");
    read_check(A_DATA, 16'h0022, "rd DATA after overrun");
    read_check(A_STAT, 16'h0001, "stat after overrun read");

    // DATA read on the same edge a new byte completes
    send_rx(8'h33, 1'b1, 16'h0000, 0, got);
    send_rx(8'h44, 1'b1, A_DATA, 10, got);
    check("rd DATA coincident returns old byte", got, 16'h0033);
    read_check(A_STAT, 16'h0005, "stat after coincident read");
    read_check(A_DATA, 16'h0044, "rd DATA new byte");

    // Glitch reject, then a framing error
    rxd = 1'b0;
    repeat (5) tick();
    rxd = 1'b1;
    repeat (30) tick();
    read_check(A_STAT, 16'h0001, "stat after glitch");
    send_rx(8'h7F, 1'b0, 16'h0000, 0, got);
    repeat (4) tick();
    read_check(A_STAT, 16'h0021, "stat framing error");
    read_check(A_STAT, 16'h0001, "stat ferr cleared");
    read_check(A_DATA, 16'h0000, "rd DATA after framing error");

    // Reset during data bit 3 of 0x0F with another byte queued
    bus_write(A_DATA, 16'h000F);
    bus_write(A_DATA, 16'h0000);
    repeat (70) tick();
    #3;
    rst = 1'b1;
    #1;
    check("txd at async reset", {15'b0, txd}, 16'h0001);
    check("rd_data at async reset", rd_data, 16'h0000);
    tick();
    rst = 1'b0;
    read_check(A_STAT, 16'h0001, "stat after mid-frame reset");
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1) bad++;
      tick();
    end
    check("txd quiet after reset (bad clocks)", 16'(bad), 16'h0000);
    read_check(A_STAT, 16'h0001, "stat end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
